// File: rtl/vga_hsync_line_capture_if.sv
// rtl/vga_hsync_line_capture_if.sv - video-in / capture-out bundle for vga_hsync_line_capture
//
// Purpose: groups the timing-generator inputs (HSYNC, rgb) with the
// recovered pixel/line/status outputs of the line capture block.
//   HSYNC, rgb        : video from the generator (active-low sync, 1-bit pixel)
//   pixel_valid/col/data : per-pixel strobe, column and sampled value
//   line_valid/line_data : end-of-line strobe and the captured line
//   locked, sync_err, err_count : timing status
// Modports: master drives video and observes results, slave is the capture block.
interface vga_hsync_line_capture_if #(
  parameter int HPIXELS = 128
);
  localparam int COL_W = $clog2(HPIXELS);

  logic               HSYNC;
  logic               rgb;
  logic               pixel_valid;
  logic [COL_W-1:0]   pixel_col;
  logic               pixel_data;
  logic [HPIXELS-1:0] line_data;
  logic               line_valid;
  logic               locked;
  logic               sync_err;
  logic [7:0]         err_count;

  modport master (
    output HSYNC, rgb,
    input  pixel_valid, pixel_col, pixel_data, line_data, line_valid,
    input  locked, sync_err, err_count
  );

  modport slave (
    input  HSYNC, rgb,
    output pixel_valid, pixel_col, pixel_data, line_data, line_valid,
    output locked, sync_err, err_count
  );
endinterface

// File: rtl/vga_hsync_line_capture.sv
// rtl/vga_hsync_line_capture.sv - horizontal VGA timing checker and line grabber
//
// Purpose: follows HSYNC from the horizontal timing generator, checks sync
// width, back porch, active length and front porch, samples rgb in the middle
// of every pixel and assembles one line per HSYNC period.
// Ports:
//   clk   : system clock shared with the generator
//   reset : synchronous, active-high
//   bus   : slave side of vga_hsync_line_capture_if (HSYNC/rgb in,
//           pixel/line strobes, locked, sync_err, err_count out)
module vga_hsync_line_capture #(
  parameter int CYCLES_PER_PIXEL = 20,
  parameter int HPIXELS          = 128,
  parameter int DISP_CYCLES      = 2560,
  parameter int FP_CYCLES        = 64,
  parameter int SYNC_CYCLES      = 384,
  parameter int BP_CYCLES        = 192,
  parameter int TOL              = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  vga_hsync_line_capture_if.slave  bus
);

  localparam int CNT_W = 12;
  localparam int COL_W = $clog2(HPIXELS);
  localparam int PH_W  = $clog2(CYCLES_PER_PIXEL);

  localparam logic [CNT_W-1:0] SYNC_MIN = CNT_W'(SYNC_CYCLES - TOL);
  localparam logic [CNT_W-1:0] SYNC_MAX = CNT_W'(SYNC_CYCLES + TOL);
  localparam logic [CNT_W-1:0] BP_LAST  = CNT_W'(BP_CYCLES - 1);
  localparam logic [CNT_W-1:0] K_LAST   = CNT_W'(DISP_CYCLES - 1);
  localparam logic [CNT_W-1:0] FP_MIN   = CNT_W'(FP_CYCLES - TOL);
  localparam logic [CNT_W-1:0] FP_MAX   = CNT_W'(FP_CYCLES + TOL);
  localparam logic [PH_W-1:0]  PH_SAMP  = PH_W'(CYCLES_PER_PIXEL / 2);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CYCLES_PER_PIXEL - 1);

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_SYNC,
    ST_BP,
    ST_ACTIVE,
    ST_FP
  } state_t;

  state_t             state_q, state_d;
  logic               hs_q, hs_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               pixel_valid_q, pixel_valid_d;
  logic [COL_W-1:0]   pixel_col_q, pixel_col_d;
  logic               pixel_data_q, pixel_data_d;
  logic [HPIXELS-1:0] line_data_q, line_data_d;
  logic               line_valid_q, line_valid_d;
  logic               locked_q, locked_d;
  logic               sync_err_q, sync_err_d;
  logic [7:0]         err_count_q, err_count_d;

  logic fall;
  logic err_evt;
  logic accept_evt;
  logic sample_evt;
  logic line_done_evt;

  // hs_q resets to 0 so a sync held low through reset release is not a fall.
  assign fall = !bus.HSYNC && hs_q;
  assign hs_d = bus.HSYNC;

  // State register (also holds the datapath flops).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_HUNT;
      hs_q          <= 1'b0;
      cnt_q         <= '0;
      phase_q       <= '0;
      col_q         <= '0;
      pixel_valid_q <= 1'b0;
      pixel_col_q   <= '0;
      pixel_data_q  <= 1'b0;
      line_data_q   <= '0;
      line_valid_q  <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hs_d;
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      col_q         <= col_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_col_q   <= pixel_col_d;
      pixel_data_q  <= pixel_data_d;
      line_data_q   <= line_data_d;
      line_valid_q  <= line_valid_d;
      locked_q      <= locked_d;
      sync_err_q    <= sync_err_d;
      err_count_q   <= err_count_d;
    end
  end

  // Next-state logic. cnt_q is the number of samples already counted in the
  // current state; the sample arriving now is number cnt_q+1 (or k = cnt_q in
  // ACTIVE).
  always_comb begin
    state_d       = state_q;
    err_evt       = 1'b0;
    accept_evt    = 1'b0;
    sample_evt    = 1'b0;
    line_done_evt = 1'b0;
    case (state_q)
      ST_HUNT: begin
        if (fall) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (!bus.HSYNC) begin
          // This low sample would make the width SYNC_MAX+1.
          if (cnt_q == SYNC_MAX) err_evt = 1'b1;
        end else if (cnt_q >= SYNC_MIN && cnt_q <= SYNC_MAX) begin
          state_d = ST_BP;
        end else begin
          err_evt = 1'b1;
        end
      end
      ST_BP: begin
        if (!bus.HSYNC)            err_evt = 1'b1;
        else if (cnt_q == BP_LAST) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!bus.HSYNC) begin
          err_evt = 1'b1;
        end else begin
          if (phase_q == PH_SAMP) sample_evt = 1'b1;
          if (cnt_q == K_LAST) begin
            state_d       = ST_FP;
            line_done_evt = 1'b1;
          end
        end
      end
      ST_FP: begin
        // The last ACTIVE sample was high, so any low sample here is a fall.
        if (!bus.HSYNC) begin
          if (cnt_q >= FP_MIN) begin
            accept_evt = 1'b1;
            state_d    = ST_SYNC;
          end else begin
            err_evt = 1'b1;
          end
        end else if (cnt_q == FP_MAX) begin
          err_evt = 1'b1;
        end
      end
      default: state_d = ST_HUNT;
    endcase
    if (err_evt) state_d = ST_HUNT;
  end

  // Output / datapath logic.
  always_comb begin
    cnt_d         = cnt_q;
    phase_d       = phase_q;
    col_d         = col_q;
    pixel_valid_d = 1'b0;
    pixel_col_d   = pixel_col_q;
    pixel_data_d  = pixel_data_q;
    line_data_d   = line_data_q;
    line_valid_d  = 1'b0;
    locked_d      = locked_q;
    sync_err_d    = 1'b0;
    err_count_d   = err_count_q;

    // The sample that causes a SYNC or BP entry is that state's first sample.
    if (state_d != state_q) begin
      cnt_d = (state_d == ST_SYNC || state_d == ST_BP) ? CNT_W'(1) : '0;
    end else if (state_q != ST_HUNT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (state_q == ST_BP && state_d == ST_ACTIVE) begin
      phase_d     = '0;
      col_d       = '0;
      line_data_d = '0;
    end else if (state_q == ST_ACTIVE) begin
      if (phase_q == PH_LAST) begin
        phase_d = '0;
        col_d   = col_q + COL_W'(1);
      end else begin
        phase_d = phase_q + PH_W'(1);
      end
    end

    if (sample_evt) begin
      line_data_d[col_q] = bus.rgb;
      pixel_valid_d      = 1'b1;
      pixel_col_d        = col_q;
      pixel_data_d       = bus.rgb;
    end

    if (line_done_evt) line_valid_d = 1'b1;
    if (accept_evt)    locked_d     = 1'b1;

    if (err_evt) begin
      sync_err_d = 1'b1;
      locked_d   = 1'b0;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end
  end

  assign bus.pixel_valid = pixel_valid_q;
  assign bus.pixel_col   = pixel_col_q;
  assign bus.pixel_data  = pixel_data_q;
  assign bus.line_data   = line_data_q;
  assign bus.line_valid  = line_valid_q;
  assign bus.locked      = locked_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_vga_hsync_line_capture.sv
// tb/tb_vga_hsync_line_capture.sv - directed bench for vga_hsync_line_capture
module tb_vga_hsync_line_capture;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_pass   = 0;

  int pv_cnt, lv_cnt, se_cnt, col_bad, exp_col, last_col;
  logic [127:0] last_line;
  logic [127:0] pat_a, pat_b;

  vga_hsync_line_capture_if vif ();

  vga_hsync_line_capture dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic clear_mon();
    pv_cnt   = 0;
    lv_cnt   = 0;
    se_cnt   = 0;
    col_bad  = 0;
    exp_col  = 0;
    last_col = -1;
  endtask

  // Drive one clock of inputs, then observe outputs 1 time unit after the edge.
  task automatic step(input logic hs, input logic r);
    vif.HSYNC = hs;
    vif.rgb   = r;
    @(posedge clk);
    #1;
    if (vif.pixel_valid) begin
      if (int'(vif.pixel_col) != exp_col) col_bad++;
      exp_col++;
      pv_cnt++;
      last_col = int'(vif.pixel_col);
    end
    if (vif.line_valid) begin
      lv_cnt++;
      last_line = vif.line_data;
    end
    if (vif.sync_err) se_cnt++;
  endtask

  task automatic low(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic high(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  task automatic active(input logic [127:0] pat, input int glitch_k, input int n);
    for (int k = 0; k < n; k++) step((k == glitch_k) ? 1'b0 : 1'b1, pat[k/20]);
  endtask

  task automatic front(input int w, input logic [127:0] pat);
    low(w);
    high(192);
    active(pat, -1, 2560);
  endtask

  initial begin
    reset     = 1'b1;
    vif.HSYNC = 1'b1;
    vif.rgb   = 1'b0;
    last_line = '0;
    pat_a     = {64{2'b01}};
    pat_b     = 128'hDEADBEEF_0F1E2D3C_A5A5_5A5A_1234_8765;
    clear_mon();

    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("rst_pixel_valid", 128'(vif.pixel_valid), 128'd0);
    check("rst_pixel_col",   128'(vif.pixel_col),   128'd0);
    check("rst_line_data",   vif.line_data,         128'd0);
    check("rst_line_valid",  128'(vif.line_valid),  128'd0);
    check("rst_locked",      128'(vif.locked),      128'd0);
    check("rst_sync_err",    128'(vif.sync_err),    128'd0);
    check("rst_err_count",   128'(vif.err_count),   128'd0);
    reset = 1'b0;
    high(5);

    // Nominal line from HUNT.
    clear_mon();
    front(384, pat_a);
    high(64);
    check("nom_pv_cnt",   128'(pv_cnt),  128'd128);
    check("nom_col_seq",  128'(col_bad), 128'd0);
    check("nom_lv_cnt",   128'(lv_cnt),  128'd1);
    check("nom_line",     last_line,     128'h5555_5555_5555_5555_5555_5555_5555_5555);
    check("nom_hold",     vif.line_data, 128'h5555_5555_5555_5555_5555_5555_5555_5555);
    check("nom_unlocked", 128'(vif.locked), 128'd0);
    low(1);
    check("nom_locked",   128'(vif.locked),    128'd1);
    check("nom_errcnt",   128'(vif.err_count), 128'd0);

    // Sync width 386 (upper tolerance).
    clear_mon();
    low(385);
    high(192);
    active(pat_b, -1, 2560);
    high(64);
    check("w386_pv_cnt", 128'(pv_cnt), 128'd128);
    check("w386_line",   last_line,    128'hDEADBEEF_0F1E2D3C_A5A5_5A5A_1234_8765);
    check("w386_se",     128'(se_cnt), 128'd0);
    low(1);
    check("w386_locked", 128'(vif.locked), 128'd1);

    // Sync width 382 (lower tolerance).
    clear_mon();
    low(381);
    high(192);
    active(pat_a, -1, 2560);
    high(64);
    check("w382_pv_cnt", 128'(pv_cnt), 128'd128);
    check("w382_lv_cnt", 128'(lv_cnt), 128'd1);
    check("w382_se",     128'(se_cnt), 128'd0);

    // Sync width 387: error on the 387th low sample.
    low(1);
    clear_mon();
    low(385);
    check("w387_no_early_err", 128'(se_cnt), 128'd0);
    low(1);
    check("w387_sync_err", 128'(vif.sync_err),  128'd1);
    check("w387_errcnt",   128'(vif.err_count), 128'd1);
    check("w387_locked",   128'(vif.locked),    128'd0);
    low(3);
    high(192);
    active(pat_a, -1, 2560);
    high(64);
    check("w387_hunt_pv", 128'(pv_cnt), 128'd0);
    check("w387_se_once", 128'(se_cnt), 128'd1);

    // Recover, then a one-cycle low pulse at pixel 40 of the next line.
    front(384, pat_a);
    high(64);
    clear_mon();
    low(1);
    check("gl_locked_before", 128'(vif.locked), 128'd1);
    low(383);
    high(192);
    active(pat_a, 40*20 + 5, 2560);
    high(64);
    check("gl_se",       128'(se_cnt),        128'd1);
    check("gl_lv",       128'(lv_cnt),        128'd0);
    check("gl_pv_cnt",   128'(pv_cnt),        128'd40);
    check("gl_last_col", 128'(last_col),      128'd39);
    check("gl_col_seq",  128'(col_bad),       128'd0);
    check("gl_locked",   128'(vif.locked),    128'd0);
    check("gl_errcnt",   128'(vif.err_count), 128'd2);

    // Front porch of 61 followed by a fall: too short.
    front(384, pat_a);
    high(61);
    low(1);
    check("fp61_sync_err", 128'(vif.sync_err),  128'd1);
    check("fp61_errcnt",   128'(vif.err_count), 128'd3);
    low(383);
    high(10);

    // Front porch runs to 67 high samples with no fall.
    front(384, pat_a);
    clear_mon();
    high(66);
    check("fp67_no_early_err", 128'(se_cnt), 128'd0);
    high(1);
    check("fp67_sync_err", 128'(vif.sync_err),  128'd1);
    check("fp67_errcnt",   128'(vif.err_count), 128'd4);
    high(10);

    // Front porch of 62 is the shortest accepted.
    front(384, pat_a);
    high(62);
    low(1);
    check("fp62_locked",  128'(vif.locked),    128'd1);
    check("fp62_errcnt",  128'(vif.err_count), 128'd4);

    // Reset at k=1000 with HSYNC low on the same edge (would also be an error).
    low(383);
    high(192);
    active(pat_a, -1, 1000);
    reset = 1'b1;
    step(1'b0, 1'b1);
    check("mid_rst_pixel_col", 128'(vif.pixel_col), 128'd0);
    check("mid_rst_line_data", vif.line_data,       128'd0);
    check("mid_rst_errcnt",    128'(vif.err_count), 128'd0);
    check("mid_rst_sync_err",  128'(vif.sync_err),  128'd0);
    check("mid_rst_locked",    128'(vif.locked),    128'd0);
    reset = 1'b0;
    clear_mon();
    low(400);
    high(192);
    active(pat_b, -1, 2560);
    high(64);
    check("mid_rst_no_sync_pv", 128'(pv_cnt), 128'd0);
    check("mid_rst_no_sync_se", 128'(se_cnt), 128'd0);
    clear_mon();
    front(384, pat_b);
    high(64);
    check("post_rst_pv_cnt", 128'(pv_cnt), 128'd128);
    check("post_rst_line",   last_line,    128'hDEADBEEF_0F1E2D3C_A5A5_5A5A_1234_8765);

    // 300 short sync pulses: counter saturates.
    clear_mon();
    for (int i = 0; i < 300; i++) begin
      low(100);
      high(10);
    end
    check("sat_se_cnt", 128'(se_cnt),        128'd300);
    check("sat_errcnt", 128'(vif.err_count), 128'd255);
    check("sat_locked", 128'(vif.locked),    128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_hsync_line_capture.md
# vga_hsync_line_capture

Receive-side companion to the horizontal VGA timing generator: consumes the generator's HSYNC and 1-bit rgb, checks horizontal timing against the generator's parameters, and recovers pixel column and value. Used as a loopback checker and line grabber in the video path. It captures one 128-pixel line per HSYNC period and flags any timing violation.

## Interface
- CYCLES_PER_PIXEL, 20, clk cycles per pixel
- HPIXELS, 128, pixels per line
- DISP_CYCLES, 2560, active cycles per line; must equal CYCLES_PER_PIXEL*HPIXELS
- FP_CYCLES, 64, front porch length
- SYNC_CYCLES, 384, HSYNC low pulse length
- BP_CYCLES, 192, back porch length
- TOL, 2, accepted ± deviation on sync width and front porch

- clk  in  1  system clock, shared with the generator
- reset  in  1  synchronous, active-high
- HSYNC  in  1  horizontal sync, active low
- rgb  in  1  pixel value
- pixel_valid  out  1  one-cycle strobe: pixel_col/pixel_data valid
- pixel_col  out  7  recovered column, 0..127
- pixel_data  out  1  sampled rgb
- line_data  out  128  captured line; bit p = pixel p
- line_valid  out  1  one-cycle strobe: line_data complete
- locked  out  1  timing verified on the most recent line
- sync_err  out  1  one-cycle strobe on any timing violation
- err_count  out  8  saturating violation counter

## Operation
- Edge detect: hs_q <= HSYNC (reset value 0). Fall = HSYNC sampled 0 while hs_q==1. HSYNC held low through reset release is not a fall.
- Counter cnt: 12 bits, cleared on every state transition.
- HUNT (reset state): wait for a fall, then go to SYNC with cnt=1.
- SYNC: cnt increments per low sample. Width W = number of low samples.
  - On the first high sample: if SYNC_CYCLES-TOL ≤ W ≤ SYNC_CYCLES+TOL, go to BP. That sample is BP cycle 1. Otherwise raise an error.
  - If W reaches SYNC_CYCLES+TOL+1 while HSYNC is still low, raise an error immediately.
- BP: after BP_CYCLES high samples, go to ACTIVE with k=0. A low sample in BP raises an error.
- ACTIVE: k = 0..DISP_CYCLES-1.
  - Pixel p = k / CYCLES_PER_PIXEL.
  - Sample rgb when k mod CYCLES_PER_PIXEL == CYCLES_PER_PIXEL/2 (integer division; 10 at default). The sample writes line_data[p].
  - After k=DISP_CYCLES-1, go to FP.
  - A low sample in ACTIVE raises an error.
- FP: count high samples F.
  - A fall with FP_CYCLES-TOL ≤ F ≤ FP_CYCLES+TOL is accepted: set locked=1 and go to SYNC with cnt=1.
  - A fall with F < FP_CYCLES-TOL raises an error.
  - F reaching FP_CYCLES+TOL+1 without a fall raises an error.
- Error handling: sync_err=1 for one cycle, err_count+1 (saturates at 255), locked=0, line_valid suppressed for the current line, go to HUNT. HUNT requires a fresh fall.
- line_data is cleared to 0 on entry to ACTIVE and holds its value after the line completes until the next ACTIVE entry.

## Timing
- Reset (synchronous): the cycle after reset is sampled high, every output is 0 (pixel_col=0, line_data=0, err_count=0) and the state is HUNT. Reset mid-line abandons the line.
- pixel_valid, pixel_col and pixel_data are registered: asserted the cycle after the sampling edge.
- line_valid is asserted in the cycle after the ACTIVE→FP transition, i.e. one cycle after the k=DISP_CYCLES-1 edge. line_data is final in that same cycle.
- sync_err is asserted in the cycle after the edge that detects the violation. err_count updates in the same cycle.
- locked rises in the cycle after the accepted FP fall and stays high through the following line unless an error occurs.
- Nominal line period: SYNC_CYCLES+BP_CYCLES+DISP_CYCLES+FP_CYCLES = 3200 cycles. The module produces exactly HPIXELS pixel_valid strobes per good line.
- Simultaneous reset and error: reset wins; err_count stays 0.

## Test plan
- Nominal line: HSYNC low 384, high 192, rgb alternating 1,0 per 20-cycle pixel, FP 64, then the next fall. Required: 128 pixel_valid strobes with cols 0..127, one line_valid, line_data = 128'h5555…5 (bit0=1), locked=1 after the second fall, err_count=0.
- Sync width 386, then 382: both lines accepted, no sync_err. Sync width 387: sync_err one cycle after the 387th low sample, err_count=1, no pixel_valid until the next valid sync.
- HSYNC pulsed low for 1 cycle during ACTIVE at pixel 40: sync_err, locked=0, no line_valid for that line, pixel_valid stops at col ≤ 40, state returns to HUNT.
- FP of 61 cycles (early fall): error. FP of 67 with no fall: error at the 67th high sample.
- Reset asserted at k=1000 of ACTIVE with HSYNC held low across reset release: all outputs 0 next cycle, no SYNC entry until HSYNC goes high and then falls again.
- 300 consecutive bad sync widths (100 cycles each): err_count saturates at 255 and stays there, one sync_err strobe per bad pulse.
